// File: rtl/if_id_fetch_queue_pkg.sv
// Shared IF/ID definitions: fetch-entry record, NOP word, PC step and
// queue occupancy classification.
package if_id_fetch_queue_pkg;

    localparam logic [31:0] NOP_WORD = 32'h00000000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

endpackage

// File: rtl/if_id_fetch_queue_mem.sv
// Fetch queue storage: DEPTH entries, synchronous write, asynchronous read.
module if_id_fetch_queue_mem
    import if_id_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t  wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t  rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF->ID decoupling queue: first-word fall-through, fetch back-pressure via
// in_ready, and a branch-taken flush that drops every queued entry.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  pc_in,
    input  logic [31:0]                  instr_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [31:0]                  id_pc,
    output logic [31:0]                  id_pc_plus4,
    output logic [31:0]                  id_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    occ_t          occ;
    logic          push;
    logic          pop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    // Occupancy comes only from registered count, so in_ready has no path from id_ready.
    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == CW'(DEPTH)) begin
            occ = OCC_FULL;
        end
    end

    assign in_ready = (occ != OCC_FULL);
    assign id_valid = (occ != OCC_EMPTY);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;

    assign wr_entry.pc    = pc_in;
    assign wr_entry.instr = instr_in;

    if_id_fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign id_pc       = id_valid ? head.pc    : '0;
    assign id_instr    = id_valid ? head.instr : NOP_INSTR;
    assign id_pc_plus4 = id_pc + PC_STEP;
    assign count       = count_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed vector table, reset
// corner cases, and randomized traffic against a queue-based reference model.
module tb_if_id_fetch_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc_in;
    logic [31:0]   instr_in;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          id_ready;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_pc_plus4;
    logic [31:0]   id_instr;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    if_id_fetch_queue #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (32'h00000000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        flush;
        logic        id_ready;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        int          e_count;
        logic        e_in_ready;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    vec_t   vecs[$];
    entry_t model_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic [31:0] p, input logic [31:0] i,
                           input logic f, input logic r, input logic ev,
                           input logic [31:0] ep, input logic [31:0] ep4,
                           input logic [31:0] ei, input int ec, input logic er);
        vec_t t;
        t.in_valid = v; t.pc = p; t.instr = i; t.flush = f; t.id_ready = r;
        t.e_valid = ev; t.e_pc = ep; t.e_pc4 = ep4; t.e_instr = ei;
        t.e_count = ec; t.e_in_ready = er;
        vecs.push_back(t);
    endtask

    // Drive inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic v, input logic [31:0] p, input logic [31:0] i,
                        input logic f, input logic r);
        in_valid = v; pc_in = p; instr_in = i; flush = f; id_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; pc_in = '0; instr_in = '0; flush = 0; id_ready = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        model_q.delete();
    endtask

    task automatic check_model(input string tag);
        logic [31:0] epc, ei;
        epc = (model_q.size() != 0) ? model_q[0].pc : 32'h0;
        ei  = (model_q.size() != 0) ? model_q[0].instr : 32'h0;
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(model_q.size() != 0));
        chk({tag, ".id_pc"}, id_pc, epc);
        chk({tag, ".id_pc_plus4"}, id_pc_plus4, epc + 32'd4);
        chk({tag, ".id_instr"}, id_instr, ei);
        chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() < DEPTH));
    endtask

    initial begin
        // Directed table: expected values are the outputs after the applied edge.
        add_vec(1, 32'h100, 32'h20080005, 0, 0, 1, 32'h100, 32'h104, 32'h20080005, 1, 1);
        add_vec(0, 32'h0,   32'h0,        0, 1, 0, 32'h0,   32'h4,   32'h0,        0, 1);
        add_vec(1, 32'h100, 32'hAAAA0001, 0, 0, 1, 32'h100, 32'h104, 32'hAAAA0001, 1, 1);
        add_vec(1, 32'h104, 32'hBBBB0002, 0, 0, 1, 32'h100, 32'h104, 32'hAAAA0001, 2, 0);
        add_vec(1, 32'h108, 32'hCCCC0003, 0, 0, 1, 32'h100, 32'h104, 32'hAAAA0001, 2, 0);
        add_vec(1, 32'h10C, 32'hCCCC0004, 0, 1, 1, 32'h104, 32'h108, 32'hBBBB0002, 1, 1);
        add_vec(0, 32'h0,   32'h0,        0, 1, 0, 32'h0,   32'h4,   32'h0,        0, 1);
        add_vec(1, 32'h200, 32'hD0000200, 0, 0, 1, 32'h200, 32'h204, 32'hD0000200, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            add_vec(1, 32'h200 + 32'(4 * k), 32'hD0000200 + 32'(k), 0, 1,
                    1, 32'h200 + 32'(4 * k), 32'h204 + 32'(4 * k), 32'hD0000200 + 32'(k), 1, 1);
        end
        add_vec(1, 32'h218, 32'hD0000218, 0, 0, 1, 32'h214, 32'h218, 32'hD0000205, 2, 0);
        add_vec(1, 32'h300, 32'hE0000300, 1, 1, 0, 32'h0,   32'h4,   32'h0,        0, 1);
        add_vec(0, 32'h0,   32'h0,        0, 1, 0, 32'h0,   32'h4,   32'h0,        0, 1);
        add_vec(1, 32'hFFFFFFFC, 32'hF00DF00D, 0, 0, 1, 32'hFFFFFFFC, 32'h0, 32'hF00DF00D, 1, 1);

        do_reset();
        chk("reset.id_valid", 32'(id_valid), 32'h0);
        chk("reset.id_pc", id_pc, 32'h0);
        chk("reset.id_pc_plus4", id_pc_plus4, 32'h4);
        chk("reset.id_instr", id_instr, 32'h0);
        chk("reset.count", 32'(count), 32'h0);
        chk("reset.in_ready", 32'(in_ready), 32'h1);

        foreach (vecs[n]) begin
            step(vecs[n].in_valid, vecs[n].pc, vecs[n].instr, vecs[n].flush, vecs[n].id_ready);
            chk($sformatf("vec%0d.id_valid", n), 32'(id_valid), 32'(vecs[n].e_valid));
            chk($sformatf("vec%0d.id_pc", n), id_pc, vecs[n].e_pc);
            chk($sformatf("vec%0d.id_pc_plus4", n), id_pc_plus4, vecs[n].e_pc4);
            chk($sformatf("vec%0d.id_instr", n), id_instr, vecs[n].e_instr);
            chk($sformatf("vec%0d.count", n), 32'(count), 32'(vecs[n].e_count));
            chk($sformatf("vec%0d.in_ready", n), 32'(in_ready), 32'(vecs[n].e_in_ready));
        end

        // Asynchronous reset between edges while full.
        do_reset();
        step(1, 32'h400, 32'h11110000, 0, 0);
        step(1, 32'h404, 32'h11110004, 0, 0);
        chk("areset.pre_count", 32'(count), 32'h2);
        @(negedge clk);
        reset = 0;
        #1;
        chk("areset.count", 32'(count), 32'h0);
        chk("areset.id_valid", 32'(id_valid), 32'h0);
        chk("areset.in_ready", 32'(in_ready), 32'h1);
        #2;
        reset = 1;
        model_q.delete();
        step(0, 32'h0, 32'h0, 0, 0);
        check_model("post_areset");

        // Randomized traffic against the queue model.
        for (int c = 0; c < 500; c++) begin
            logic        v, f, r;
            logic [31:0] p, i;
            bit          do_push, do_pop;
            entry_t      e;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 15) == 0);
            p = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            i = $urandom;
            do_push = v && (model_q.size() < DEPTH) && !f;
            do_pop  = (model_q.size() != 0) && r && !f;
            step(v, p, i, f, r);
            if (f) begin
                model_q.delete();
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    e.pc = p;
                    e.instr = i;
                    model_q.push_back(e);
                end
            end
            check_model($sformatf("rand%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
